// File: rtl/wavetable_reader.sv
`default_nettype none
// ============================================================================
// Module      : wavetable_reader
// Description : NCO wavetable read side. Advances a phase accumulator per
//               sample tick, reads two adjacent samples from a 1-cycle ROM
//               and emits their linear interpolation.
// Revision    : 1.0 - initial release
// ============================================================================
module wavetable_reader #(
    parameter int PHASE_W   = 24,
    parameter int IDX_W     = 7,
    parameter int TABLE_LEN = 128,
    parameter int NUM_WAVES = 5,
    parameter int ADDR_W    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_rst,
    input  logic [2:0]         wave_sel,
    output logic               rom_re,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic [7:0]         out_sample,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_CAP1 = 3'd3,
        S_CALC = 3'd4
    } state_t;

    localparam logic [2:0] C_WS_MAX = 3'(NUM_WAVES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [PHASE_W-1:0]  r_phase;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_frac;
    logic [ADDR_W-1:0]   r_base;
    logic [7:0]          r_s0;
    logic [7:0]          r_s1;

    logic                w_accept;
    logic [PHASE_W-1:0]  w_p;
    logic [2:0]          w_ws;
    logic [ADDR_W-1:0]   w_base;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic signed [8:0]   w_diff;
    logic signed [16:0]  w_prod;
    logic signed [16:0]  w_shift;
    logic signed [16:0]  w_sum;
    logic                w_unused_hi;

    assign w_accept  = sample_tick && (r_state == S_IDLE);
    assign w_p       = phase_rst ? '0 : r_phase;
    assign w_ws      = (wave_sel > C_WS_MAX) ? C_WS_MAX : wave_sel;
    assign w_base    = ADDR_W'(w_ws) * ADDR_W'(TABLE_LEN);
    // Second read wraps within the current table rather than spilling into the next wave
    assign w_idx_nxt = r_idx + IDX_W'(1);

    assign w_diff  = $signed({1'b0, r_s1}) - $signed({1'b0, r_s0});
    assign w_prod  = $signed({{8{w_diff[8]}}, w_diff}) * $signed({9'd0, r_frac});
    assign w_shift = w_prod >>> 8;
    assign w_sum   = $signed({9'd0, r_s0}) + w_shift;
    assign w_unused_hi = ^w_sum[16:8];

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_tick) w_next = S_RD0;
            S_RD0:   w_next = S_RD1;
            S_RD1:   w_next = S_CAP1;
            S_CAP1:  w_next = S_CALC;
            S_CALC:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_idx      <= '0;
            r_frac     <= '0;
            r_base     <= '0;
            r_s0       <= '0;
            r_s1       <= '0;
            rom_re     <= 1'b0;
            rom_addr   <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_phase  <= w_p + phase_inc;
                        r_idx    <= w_p[PHASE_W-1 -: IDX_W];
                        r_frac   <= w_p[PHASE_W-1-IDX_W -: 8];
                        r_base   <= w_base;
                        rom_re   <= 1'b1;
                        rom_addr <= w_base + ADDR_W'(w_p[PHASE_W-1 -: IDX_W]);
                    end
                end
                S_RD0: begin
                    rom_addr <= r_base + ADDR_W'(w_idx_nxt);
                end
                S_RD1: begin
                    r_s0   <= rom_data;
                    rom_re <= 1'b0;
                end
                S_CAP1: begin
                    r_s1 <= rom_data;
                end
                S_CALC: begin
                    out_sample <= w_sum[7:0];
                    out_valid  <= 1'b1;
                end
                default: begin
                    rom_re <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wavetable_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wavetable_reader
// Description : Scoreboard bench for wavetable_reader with a behavioural ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wavetable_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic [23:0] phase_inc;
    logic        phase_rst;
    logic [2:0]  wave_sel;
    logic        rom_re;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic [7:0]  out_sample;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    logic [23:0] m_phase;

    wavetable_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .phase_inc  (phase_inc),
        .phase_rst  (phase_rst),
        .wave_sel   (wave_sel),
        .rom_re     (rom_re),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_img(input int addr);
        int w, i;
        w = addr / 128;
        i = addr % 128;
        return 8'((2 * i + 8 * w) & 255);
    endfunction

    always @(posedge clk) begin
        if (rom_re) rom_data <= rom_img(int'(rom_addr));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
            else check("sample", 32'(out_sample), 32'(exp_q.pop_front()));
        end
    end

    // Reference: floor division of the signed product, done on plain integers
    task automatic push_exp(input logic [23:0] inc, input logic prst, input logic [2:0] ws,
                            output int base, output int idx);
        logic [23:0] p;
        int w, frac, s0, s1, prod, q;
        p     = prst ? 24'd0 : m_phase;
        m_phase = p + inc;
        w     = (ws > 3'd4) ? 4 : int'(ws);
        base  = w * 128;
        idx   = int'(p[23:17]);
        frac  = int'(p[16:9]);
        s0    = int'(rom_img(base + idx));
        s1    = int'(rom_img(base + ((idx + 1) % 128)));
        prod  = (s1 - s0) * frac;
        q     = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
        exp_q.push_back(s0 + q);
    endtask

    task automatic do_tick(input logic [23:0] inc, input logic prst, input logic [2:0] ws);
        int base, idx;
        push_exp(inc, prst, ws, base, idx);
        @(negedge clk);
        sample_tick = 1'b1; phase_inc = inc; phase_rst = prst; wave_sel = ws;
        @(posedge clk); #1;
        sample_tick = 1'b0; phase_rst = 1'b0;
        check("addr0", 32'(rom_addr), 32'(base + idx));
        check("re_on", 32'(rom_re), 32'd1);
        @(posedge clk); #1;
        check("addr1", 32'(rom_addr), 32'(base + ((idx + 1) % 128)));
        @(posedge clk); #1;
        check("re_off", 32'(rom_re), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        check("latency", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, idx;
        rst_n = 1'b0; sample_tick = 1'b0; phase_inc = '0; phase_rst = 1'b0; wave_sel = '0;
        m_phase = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", 32'(out_sample), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_re", 32'(rom_re), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic stepping, ticks every 8 clocks
        for (int k = 0; k < 3; k++) begin
            do_tick(24'd1 << 17, 1'b0, 3'd0);
            repeat (3) @(posedge clk);
        end
        // Midpoint interpolation, then zero increment repeats
        do_tick(24'd1 << 16, 1'b1, 3'd0);
        do_tick(24'd1 << 16, 1'b0, 3'd0);
        do_tick(24'd0, 1'b0, 3'd0);
        do_tick(24'd0, 1'b0, 3'd0);
        // Table wrap at idx 127 with frac 128
        do_tick((24'd127 << 17) | (24'd128 << 9), 1'b1, 3'd0);
        do_tick(24'd0, 1'b0, 3'd0);
        // Wave offsets and clamping
        do_tick(24'd5 << 17, 1'b1, 3'd2);
        do_tick(24'd0, 1'b0, 3'd2);
        do_tick(24'd3 << 9, 1'b0, 3'd7);
        do_tick(24'd1 << 17, 1'b0, 3'd3);

        // Overrun: second tick two cycles after an accepted one
        check("overrun_pre", 32'(overrun), 32'd0);
        push_exp(24'd1 << 17, 1'b0, 3'd0, base, idx);
        @(negedge clk);
        sample_tick = 1'b1; phase_inc = 24'd1 << 17; wave_sel = 3'd0;
        @(posedge clk); #1; sample_tick = 1'b0;
        @(posedge clk);
        @(negedge clk); sample_tick = 1'b1; phase_inc = 24'd40 << 17;
        @(posedge clk); #1; sample_tick = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (3) @(posedge clk);
        do_tick(24'd1 << 17, 1'b0, 3'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset during RD1 aborts the read
        @(negedge clk);
        sample_tick = 1'b1; phase_inc = 24'd3 << 17; wave_sel = 3'd1;
        @(posedge clk); #1; sample_tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_re", 32'(rom_re), 32'd0);
        check("abort_addr", 32'(rom_addr), 32'd0);
        check("abort_sample", 32'(out_sample), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        m_phase = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_tick(24'd1 << 17, 1'b0, 3'd0);
        do_tick(24'd1 << 17, 1'b0, 3'd1);

        repeat (4) @(posedge clk);
        check("drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
